// File: rtl/gpu_cache_fill_arbiter.sv
// gpu_cache_fill_arbiter: shares one burst-read VRAM port between the texture
// cache (1-beat lines) and palette cache (4-beat lines) refill requesters,
// writes returned beats into the owning cache and pulses its completion.
module gpu_cache_fill_arbiter (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_requTex,
  input  logic [16:0] i_adrTex,
  output logic        o_texComplete,
  input  logic        i_requClut,
  input  logic [14:0] i_adrClut,
  output logic        o_clutComplete,
  output logic        o_memReq,
  output logic [16:0] o_memAdr,
  output logic [2:0]  o_memBurst,
  input  logic        i_memAck,
  input  logic        i_memDataValid,
  input  logic [63:0] i_memData,
  output logic        o_texWr,
  output logic        o_clutWr,
  output logic [16:0] o_wrAdr,
  output logic [63:0] o_wrData
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd3,
    S_COOL = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_ownClut;
  logic        r_lastClut;
  logic [16:0] r_adr;
  logic [2:0]  r_burst;
  logic [1:0]  r_cnt;

  logic        r_texWr;
  logic        r_clutWr;
  logic [16:0] r_wrAdr;
  logic [63:0] r_wrData;

  logic        w_grant;
  logic        w_grantClut;
  logic        w_beat;
  logic        w_lastBeat;

  // Grant decision, beat qualification and next-state selection.
  always_comb begin
    w_grant     = 1'b0;
    w_grantClut = 1'b0;
    w_beat      = 1'b0;
    w_lastBeat  = 1'b0;
    w_next      = r_state;

    // On a tie the side not served last wins; a lone request always wins.
    w_grantClut = i_requClut && (!i_requTex || !r_lastClut);
    w_grant     = (r_state == S_IDLE) && (i_requTex || i_requClut);
    w_beat      = (r_state == S_DATA) && i_memDataValid;
    w_lastBeat  = w_beat && ({1'b0, r_cnt} == (r_burst - 3'd1));

    case (r_state)
      S_IDLE: if (w_grant)    w_next = S_REQ;
      S_REQ:  if (i_memAck)   w_next = S_DATA;
      S_DATA: if (w_lastBeat) w_next = S_DONE;
      S_DONE:                 w_next = S_COOL;
      S_COOL:                 w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Latched fill context: owner, start address, burst length, beat counter, tie history.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_ownClut  <= 1'b0;
      r_lastClut <= 1'b0;
      r_adr      <= 17'd0;
      r_burst    <= 3'd0;
      r_cnt      <= 2'd0;
    end else begin
      if (w_grant) begin
        r_ownClut <= w_grantClut;
        r_adr     <= w_grantClut ? {i_adrClut, 2'b00} : i_adrTex;
        r_burst   <= w_grantClut ? 3'd4 : 3'd1;
      end
      if ((r_state == S_REQ) && i_memAck) r_cnt <= 2'd0;
      else if (w_beat)                    r_cnt <= r_cnt + 2'd1;
      if (r_state == S_COOL) r_lastClut <= r_ownClut;
    end
  end

  // Cache write port: each accepted beat is written one cycle later to the owner.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_texWr  <= 1'b0;
      r_clutWr <= 1'b0;
      r_wrAdr  <= 17'd0;
      r_wrData <= 64'd0;
    end else begin
      r_texWr  <= w_beat && !r_ownClut;
      r_clutWr <= w_beat &&  r_ownClut;
      if (w_beat) begin
        // Clut starts are 4-aligned, so adding the 2-bit count never carries out.
        r_wrAdr  <= r_adr + {15'd0, r_cnt};
        r_wrData <= i_memData;
      end
    end
  end

  assign o_memReq       = (r_state == S_REQ);
  assign o_memAdr       = r_adr;
  assign o_memBurst     = r_burst;
  assign o_texWr        = r_texWr;
  assign o_clutWr       = r_clutWr;
  assign o_wrAdr        = r_wrAdr;
  assign o_wrData       = r_wrData;
  assign o_texComplete  = (r_state == S_COOL) && !r_ownClut;
  assign o_clutComplete = (r_state == S_COOL) &&  r_ownClut;

endmodule

// File: tb/tb_gpu_cache_fill_arbiter.sv
// Bench for gpu_cache_fill_arbiter: directed scenarios followed by randomized
// request/ack/beat traffic, checked against a transaction-level model.
module tb_gpu_cache_fill_arbiter;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_requTex;
  logic [16:0] i_adrTex;
  logic        o_texComplete;
  logic        i_requClut;
  logic [14:0] i_adrClut;
  logic        o_clutComplete;
  logic        o_memReq;
  logic [16:0] o_memAdr;
  logic [2:0]  o_memBurst;
  logic        i_memAck;
  logic        i_memDataValid;
  logic [63:0] i_memData;
  logic        o_texWr;
  logic        o_clutWr;
  logic [16:0] o_wrAdr;
  logic [63:0] o_wrData;

  int n_assert = 0;
  int n_fail   = 0;
  bit m_lastClut;

  always #5 clk = ~clk;

  gpu_cache_fill_arbiter dut (
    .clk            (clk),
    .i_rst          (i_rst),
    .i_requTex      (i_requTex),
    .i_adrTex       (i_adrTex),
    .o_texComplete  (o_texComplete),
    .i_requClut     (i_requClut),
    .i_adrClut      (i_adrClut),
    .o_clutComplete (o_clutComplete),
    .o_memReq       (o_memReq),
    .o_memAdr       (o_memAdr),
    .o_memBurst     (o_memBurst),
    .i_memAck       (i_memAck),
    .i_memDataValid (i_memDataValid),
    .i_memData      (i_memData),
    .o_texWr        (o_texWr),
    .o_clutWr       (o_clutWr),
    .o_wrAdr        (o_wrAdr),
    .o_wrData       (o_wrData)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("wr_exclusive", 64'(o_texWr & o_clutWr), 64'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_memReq"},   64'(o_memReq),       64'(0));
    chk({tag, "_memAdr"},   64'(o_memAdr),       64'(0));
    chk({tag, "_memBurst"}, 64'(o_memBurst),     64'(0));
    chk({tag, "_texWr"},    64'(o_texWr),        64'(0));
    chk({tag, "_clutWr"},   64'(o_clutWr),       64'(0));
    chk({tag, "_wrAdr"},    64'(o_wrAdr),        64'(0));
    chk({tag, "_wrData"},   o_wrData,            64'(0));
    chk({tag, "_texCmp"},   64'(o_texComplete),  64'(0));
    chk({tag, "_clutCmp"},  64'(o_clutComplete), 64'(0));
  endtask

  // One complete fill starting from IDLE with the bench's current requests.
  // fixed_gap < 0 picks random idle cycles before each beat.
  task automatic serve(input int ackdly, input bit early_drop, input bit extra_beat,
                       input int fixed_gap);
    bit          own_clut;
    logic [16:0] sadr;
    int          nb;
    int          gap;
    logic [63:0] d;
    own_clut = (i_requClut && i_requTex) ? !m_lastClut : i_requClut;
    sadr     = own_clut ? {i_adrClut, 2'b00} : i_adrTex;
    nb       = own_clut ? 4 : 1;

    tick();
    chk("grant_memReq",   64'(o_memReq),   64'(1));
    chk("grant_memAdr",   64'(o_memAdr),   64'(sadr));
    chk("grant_memBurst", 64'(o_memBurst), 64'(nb));
    if (early_drop) begin
      if (own_clut) i_requClut = 1'b0;
      else          i_requTex  = 1'b0;
    end

    for (int i = 0; i < ackdly; i++) begin
      i_memDataValid = 1'($urandom_range(0, 1));
      i_memData      = {$urandom, $urandom};
      tick();
      chk("wait_memReq", 64'(o_memReq), 64'(1));
      chk("wait_memAdr", 64'(o_memAdr), 64'(sadr));
      chk("wait_noWr",   64'(o_texWr | o_clutWr), 64'(0));
    end
    i_memDataValid = 1'b0;
    i_memAck       = 1'b1;
    tick();
    i_memAck = 1'b0;
    chk("acked_memReq", 64'(o_memReq), 64'(0));

    for (int k = 0; k < nb; k++) begin
      gap = (fixed_gap >= 0) ? fixed_gap : int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("gap_noWr", 64'(o_texWr | o_clutWr), 64'(0));
      end
      d              = {$urandom, $urandom};
      i_memDataValid = 1'b1;
      i_memData      = d;
      tick();
      i_memDataValid = 1'b0;
      chk("beat_texWr",  64'(o_texWr),  64'(!own_clut));
      chk("beat_clutWr", 64'(o_clutWr), 64'(own_clut));
      chk("beat_wrAdr",  64'(o_wrAdr),  64'(sadr + 17'(k)));
      chk("beat_wrData", o_wrData,      d);
      chk("beat_noCmp",  64'(o_texComplete | o_clutComplete), 64'(0));
    end

    if (extra_beat) begin
      i_memDataValid = 1'b1;
      i_memData      = {$urandom, $urandom};
    end
    tick();
    i_memDataValid = 1'b0;
    chk("cool_texCmp",  64'(o_texComplete),  64'(!own_clut));
    chk("cool_clutCmp", 64'(o_clutComplete), 64'(own_clut));
    chk("cool_noWr",    64'(o_texWr | o_clutWr), 64'(0));
    chk("cool_memReq",  64'(o_memReq), 64'(0));

    tick();
    chk("idle_noCmp",  64'(o_texComplete | o_clutComplete), 64'(0));
    chk("idle_memReq", 64'(o_memReq), 64'(0));
    if (own_clut) i_requClut = 1'b0;
    else          i_requTex  = 1'b0;
    m_lastClut = own_clut;

    if (!i_requTex && !i_requClut) begin
      tick();
      chk("no_regrant", 64'(o_memReq), 64'(0));
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst      = 1'b0;
    m_lastClut = 1'b0;
  endtask

  initial begin
    i_rst          = 1'b1;
    i_requTex      = 1'b0;
    i_adrTex       = 17'd0;
    i_requClut     = 1'b0;
    i_adrClut      = 15'd0;
    i_memAck       = 1'b0;
    i_memDataValid = 1'b0;
    i_memData      = 64'd0;
    m_lastClut     = 1'b0;

    // Reset state.
    tick();
    tick();
    chk_all_zero("reset");
    i_rst = 1'b0;
    tick();

    // Single Tex fill: ack with the request, beat three cycles after ack.
    i_adrTex  = 17'h1ABCD;
    i_requTex = 1'b1;
    serve(0, 1'b0, 1'b0, 2);

    // Single Clut fill at top of VRAM, gaps between beats.
    i_adrClut  = 15'h7FFF;
    i_requClut = 1'b1;
    serve(1, 1'b0, 1'b0, -1);

    // Stray beats in IDLE.
    for (int i = 0; i < 3; i++) begin
      i_memDataValid = 1'b1;
      i_memData      = {$urandom, $urandom};
      tick();
      i_memDataValid = 1'b0;
      chk("stray_noWr",   64'(o_texWr | o_clutWr), 64'(0));
      chk("stray_memReq", 64'(o_memReq), 64'(0));
    end

    // Simultaneous requests from reset, then a second tie.
    do_reset();
    i_adrTex   = 17'h00123;
    i_adrClut  = 15'h0456;
    i_requTex  = 1'b1;
    i_requClut = 1'b1;
    serve(0, 1'b0, 1'b1, 0);
    serve(2, 1'b0, 1'b0, 1);
    i_requTex  = 1'b1;
    i_requClut = 1'b1;
    serve(0, 1'b0, 1'b0, 0);
    serve(0, 1'b1, 1'b0, 0);

    // Reset after the second beat of a Clut fill.
    i_adrClut  = 15'h2A5A;
    i_requClut = 1'b1;
    tick();
    chk("rst_grant", 64'(o_memReq), 64'(1));
    i_requClut = 1'b0;
    i_memAck   = 1'b1;
    tick();
    i_memAck = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_memDataValid = 1'b1;
      i_memData      = {$urandom, $urandom};
      tick();
      chk("rst_beatWr", 64'(o_clutWr), 64'(1));
    end
    i_memDataValid = 1'b0;
    i_rst          = 1'b1;
    tick();
    i_rst      = 1'b0;
    m_lastClut = 1'b0;
    chk_all_zero("midrst");
    for (int k = 0; k < 4; k++) begin
      i_memDataValid = (k < 2);
      i_memData      = {$urandom, $urandom};
      tick();
      chk("midrst_noWr",   64'(o_texWr | o_clutWr), 64'(0));
      chk("midrst_noCmp",  64'(o_texComplete | o_clutComplete), 64'(0));
      chk("midrst_memReq", 64'(o_memReq), 64'(0));
    end
    i_memDataValid = 1'b0;

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      if (!i_requTex && ($urandom_range(0, 1) == 1)) begin
        i_adrTex  = 17'($urandom);
        i_requTex = 1'b1;
      end
      if (!i_requClut && ($urandom_range(0, 1) == 1)) begin
        i_adrClut  = 15'($urandom);
        i_requClut = 1'b1;
      end
      if (!i_requTex && !i_requClut) begin
        i_memDataValid = 1'b1;
        i_memData      = {$urandom, $urandom};
        tick();
        i_memDataValid = 1'b0;
        chk("rnd_stray_noWr",   64'(o_texWr | o_clutWr), 64'(0));
        chk("rnd_stray_memReq", 64'(o_memReq), 64'(0));
      end else begin
        serve(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0), -1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
